// File: rtl/ceas_pkg.sv
// rtl/ceas_pkg.sv - shared clock-set types, BCD width, range limits and BCD pair conversion
package ceas_pkg;

  typedef enum logic {
    S_TENS  = 1'b0,
    S_UNITS = 1'b1
  } state_t;

  localparam int BCD_W   = 4;
  localparam int MAX_SEC = 59;
  localparam int MAX_MIN = 59;
  localparam int MAX_ORA = 23;

  // d1*10 + d0 without a multiplier: (d1<<3) + (d1<<1) + d0 on 7 bits
  function automatic logic [6:0] bcd_pair_to_bin(input logic [BCD_W-1:0] d1,
                                                 input logic [BCD_W-1:0] d0);
    logic [6:0] t;
    t = {3'b000, d1};
    return (t << 3) + (t << 1) + {3'b000, d0};
  endfunction

endpackage

// File: rtl/asamblare_digiti_if.sv
// rtl/asamblare_digiti_if.sv - digit entry and assembled value signals between keypad decoder and set logic
interface asamblare_digiti_if #(
  parameter int OUT_W = 6
);
  import ceas_pkg::*;

  logic [BCD_W-1:0] digit_in;
  logic             digit_valid;
  logic             cancel;
  logic [OUT_W-1:0] value_out;
  logic             value_valid;
  logic             err;
  logic             busy;
  logic [BCD_W-1:0] d1_echo;

  modport master (
    output digit_in, digit_valid, cancel,
    input  value_out, value_valid, err, busy, d1_echo
  );

  modport slave (
    input  digit_in, digit_valid, cancel,
    output value_out, value_valid, err, busy, d1_echo
  );
endinterface

// File: rtl/contor_timeout.sv
// rtl/contor_timeout.sv - idle counter with clear and terminal-count flag
module contor_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !tc)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == TERM);
endmodule

// File: rtl/asamblare_digiti.sv
// rtl/asamblare_digiti.sv - assembles tens then units BCD digits into a range-checked binary value
// Optional units-digit idle timeout under macro ASAMBLARE_TIMEOUT_EN.
module asamblare_digiti
  import ceas_pkg::*;
#(
  parameter int MAX_VALUE      = MAX_SEC,
  parameter int OUT_W          = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  asamblare_digiti_if.slave bus
);
  localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(MAX_VALUE / 10);
  localparam logic [6:0]       MAX_SUM  = 7'(MAX_VALUE);

  if (MAX_VALUE > 99 || (1 << OUT_W) <= MAX_VALUE || TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("asamblare_digiti: MAX_VALUE must be <= 99 and fit OUT_W; TIMEOUT_CYCLES >= 2");
  end

  state_t           state_q, state_d;
  logic [BCD_W-1:0] d1_q, d1_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             vv_q, vv_d;
  logic             err_q, err_d;
  logic             cnt_clr;
  logic             timeout;
  logic [6:0]       sum;

  assign sum = bcd_pair_to_bin(d1_q, bus.digit_in);

`ifdef ASAMBLARE_TIMEOUT_EN
  contor_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_contor (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (state_q == S_UNITS),
    .tc   (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    value_d = value_q;
    vv_d    = 1'b0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    // cancel drops any digit presented in the same cycle
    if (bus.cancel) begin
      state_d = S_TENS;
    end else if (bus.digit_valid) begin
      case (state_q)
        S_TENS: begin
          if (bus.digit_in > 4'd9 || bus.digit_in > MAX_TENS) begin
            err_d = 1'b1;
          end else begin
            d1_d    = bus.digit_in;
            state_d = S_UNITS;
            cnt_clr = 1'b1;
          end
        end
        S_UNITS: begin
          state_d = S_TENS;
          if (bus.digit_in > 4'd9 || sum > MAX_SUM) begin
            err_d = 1'b1;
          end else begin
            value_d = sum[OUT_W-1:0];
            vv_d    = 1'b1;
          end
        end
        default: state_d = S_TENS;
      endcase
    end else if (state_q == S_UNITS && timeout) begin
      state_d = S_TENS;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_TENS;
      d1_q    <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      value_q <= value_d;
      vv_q    <= vv_d;
      err_q   <= err_d;
    end
  end

  assign bus.value_out   = value_q;
  assign bus.value_valid = vv_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q == S_UNITS);
  assign bus.d1_echo     = d1_q;
endmodule

// File: tb/tb_asamblare_digiti.sv
// tb/tb_asamblare_digiti.sv - directed and random checks of two digit assemblers (59 and 23) against a value model
module tb_asamblare_digiti;
  import ceas_pkg::*;

  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  asamblare_digiti_if #(.OUT_W(6)) if59 ();
  asamblare_digiti_if #(.OUT_W(5)) if23 ();

  asamblare_digiti #(.MAX_VALUE(MAX_SEC), .OUT_W(6), .TIMEOUT_CYCLES(TO)) u59 (
    .clk(clk), .rst_n(rst_n), .bus(if59)
  );
  asamblare_digiti #(.MAX_VALUE(MAX_ORA), .OUT_W(5), .TIMEOUT_CYCLES(TO)) u23 (
    .clk(clk), .rst_n(rst_n), .bus(if23)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: held tens digit (-1 when none), last accepted value, echo, idle age
  int m_held[2], m_val[2], m_d1[2], m_age[2];
  bit e_vv[2], e_err[2];
  int maxv[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_held[k] = -1; m_val[k] = 0; m_d1[k] = 0; m_age[k] = 0;
      e_vv[k] = 1'b0; e_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input int d, input bit dv, input bit c);
    int s;
    e_vv[k] = 1'b0;
    e_err[k] = 1'b0;
    if (c) begin
      m_held[k] = -1;
    end else if (dv) begin
      if (m_held[k] < 0) begin
        if (d > 9 || d > maxv[k] / 10) e_err[k] = 1'b1;
        else begin
          m_held[k] = d; m_d1[k] = d; m_age[k] = 0;
        end
      end else begin
        s = m_held[k] * 10 + d;
        m_held[k] = -1;
        if (d > 9 || s > maxv[k]) e_err[k] = 1'b1;
        else begin
          m_val[k] = s; e_vv[k] = 1'b1;
        end
      end
    end else if (m_held[k] >= 0) begin
`ifdef ASAMBLARE_TIMEOUT_EN
      if (m_age[k] == TO - 1) begin
        m_held[k] = -1; e_err[k] = 1'b1;
      end else begin
        m_age[k]++;
      end
`endif
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("m59.value_valid", {7'd0, if59.value_valid}, {7'd0, e_vv[0]});
    cmp("m59.err",         {7'd0, if59.err},         {7'd0, e_err[0]});
    cmp("m59.value_out",   {2'd0, if59.value_out},   8'(m_val[0]));
    cmp("m59.busy",        {7'd0, if59.busy},        {7'd0, m_held[0] >= 0});
    cmp("m59.d1_echo",     {4'd0, if59.d1_echo},     8'(m_d1[0]));
    cmp("m23.value_valid", {7'd0, if23.value_valid}, {7'd0, e_vv[1]});
    cmp("m23.err",         {7'd0, if23.err},         {7'd0, e_err[1]});
    cmp("m23.value_out",   {3'd0, if23.value_out},   8'(m_val[1]));
    cmp("m23.busy",        {7'd0, if23.busy},        {7'd0, m_held[1] >= 0});
    cmp("m23.d1_echo",     {4'd0, if23.d1_echo},     8'(m_d1[1]));
  endtask

  task automatic step(input int d, input bit dv, input bit c);
    if59.digit_in = 4'(d); if59.digit_valid = dv; if59.cancel = c;
    if23.digit_in = 4'(d); if23.digit_valid = dv; if23.cancel = c;
    model_step(0, d, dv, c);
    model_step(1, d, dv, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic digit(input int d);
    step(d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    maxv[0] = MAX_SEC;
    maxv[1] = MAX_ORA;
    if59.digit_in = '0; if59.digit_valid = 1'b0; if59.cancel = 1'b0;
    if23.digit_in = '0; if23.digit_valid = 1'b0; if23.cancel = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    apply_reset();
    idle(1);

    digit(4); digit(7); idle(1);             // 47 on the 59 unit
    digit(6); digit(5); digit(9); idle(1);   // tens 6 rejected, then 59
    digit(2); digit(4); digit(2); digit(3); idle(1);
    digit(3); step(8, 1'b1, 1'b1); idle(1);  // cancel beats digit_valid
    digit(0); digit(8); idle(1);
    digit(1); apply_reset(); digit(0); digit(5); idle(1);
    digit(15); digit(1); digit(12); idle(1); // non-BCD tens and units
    digit(5); digit(5); idle(1);             // held strobe = two digits
    digit(0); digit(0); digit(9); digit(9);
    step(7, 1'b0, 1'b1); idle(2);            // cancel with nothing held

`ifdef ASAMBLARE_TIMEOUT_EN
    digit(2); idle(TO); idle(1);             // expires on the 16th idle cycle
    digit(2); idle(TO - 1); digit(1); idle(1);
`endif

    for (int i = 0; i < 400; i++) begin
      int d;
      bit dv, c;
      d  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      dv = ($urandom_range(0, 9) < 7);
      c  = ($urandom_range(0, 19) == 0);
      step(d, dv, c);
      if ($urandom_range(0, 29) == 0) idle(int'($urandom_range(5, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
